// File: rtl/text_row_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : text_row_sequencer_pkg
// Purpose  : Shared constants for the text row sequencer: text-word attribute
//            bit positions, generator field widths and the sequencer state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package text_row_sequencer_pkg;

  // Generator field widths
  localparam int CHAR_W_DEF     = 8;   // character index width
  localparam int YCHAR_W        = 4;   // scanline-within-cell width
  localparam int PIX_PER_CELL   = 8;

  // Text memory word layout (bits [CHAR_W-1:0] hold the character index)
  localparam int ATTR_XSIZE     = 8;
  localparam int ATTR_YSIZE     = 9;
  localparam int ATTR_YPART     = 10;
  localparam int ATTR_UNDERLINE = 11;
  localparam int ATTR_INVERT    = 12;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GEN   = 3'd3,
    ST_CAPT  = 3'd4,
    ST_FULL  = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/text_row_sequencer_shifter.sv
`default_nettype none
// ============================================================================
// Module   : text_pixel_shifter
// Purpose  : 8-bit serialiser for character rows. Loads a row from the
//            prefetch register, shifts it out MSB first on pixel_en and flags
//            underrun when a pixel is requested while empty mid-line.
// Ports    : clk, reset_n     - clock, async active-low reset
//            clear            - discard contents and clear underrun (new line)
//            pixel_en         - one strobe per output pixel
//            load, load_data  - load a new 8-pixel row
//            cells_pending    - cells of the current line still to be loaded
//            pixel, busy      - serial pixel and "row bits present"
//            ready            - a load may happen this clock
//            last_shift       - this clock shifts out the final bit, no reload
//            underrun         - sticky underrun flag
// Revision : 1.0 - initial release
// ============================================================================
module text_pixel_shifter
  import text_row_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       pixel_en,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       cells_pending,
  output logic       pixel,
  output logic       busy,
  output logic       ready,
  output logic       last_shift,
  output logic       underrun
);

  localparam logic [3:0] C_FULL = 4'(PIX_PER_CELL);

  logic [7:0] r_shift;
  logic [3:0] r_count;
  logic       r_underrun;

  assign pixel      = r_shift[7];
  assign busy       = (r_count != 4'd0);
  // A reload is accepted when empty, or when the last bit leaves this clock.
  assign ready      = (r_count == 4'd0) || ((r_count == 4'd1) && pixel_en);
  assign last_shift = pixel_en && (r_count == 4'd1) && !load;
  assign underrun   = r_underrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= 8'd0;
      r_count    <= 4'd0;
      r_underrun <= 1'b0;
    end else if (clear) begin
      r_shift    <= 8'd0;
      r_count    <= 4'd0;
      r_underrun <= 1'b0;
    end else begin
      if (load) begin
        r_shift <= load_data;
        r_count <= C_FULL;
      end else if (pixel_en && (r_count != 4'd0)) begin
        r_shift <= {r_shift[6:0], 1'b0};
        r_count <= r_count - 4'd1;
      end
      // Empty shifter drains to zero, so the missed pixel is presented as 0.
      if (pixel_en && (r_count == 4'd0) && cells_pending) begin
        r_underrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/text_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : text_row_sequencer
// Purpose  : Sequences the character generator for one text scanline: reads
//            character words, decodes size/underline/invert attributes, drives
//            the generator (including the double-width half cell), captures
//            each 8-pixel row and serialises it at pixel-enable rate.
// Ports    : line_start/row_addr/ychar_in - start a scanline
//            mem_rd/mem_addr/mem_data     - text memory (1-clock read latency)
//            cg_*                         - character generator interface
//            pixel/pixel_valid            - serial pixel stream
//            line_done/underrun           - line status
// Revision : 1.0 - initial release
// ============================================================================
module text_row_sequencer
  import text_row_sequencer_pkg::*;
#(
  parameter int COLUMNS = 40,
  parameter int ADDR_W  = 12,
  parameter int CHAR_W  = CHAR_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               line_start,
  input  logic [ADDR_W-1:0]  row_addr,
  input  logic [YCHAR_W-1:0] ychar_in,
  input  logic               pixel_en,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [15:0]        mem_data,
  output logic [CHAR_W-1:0]  cg_index,
  output logic [YCHAR_W-1:0] cg_ychar,
  output logic               cg_xsize,
  output logic               cg_ysize,
  output logic               cg_xpart,
  output logic               cg_ypart,
  output logic               cg_underline,
  output logic               cg_invert,
  input  logic [7:0]         cg_pixels,
  output logic               pixel,
  output logic               pixel_valid,
  output logic               line_done,
  output logic               underrun
);

  localparam int              CNT_W     = $clog2(COLUMNS + 1);
  localparam int              ATTR_W    = ATTR_INVERT + 1;
  localparam logic [CNT_W-1:0] C_COLUMNS = CNT_W'(COLUMNS);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [ADDR_W-1:0]   r_col_addr;
  logic [CNT_W-1:0]    r_cells_left;
  logic [YCHAR_W-1:0]  r_ychar;
  logic [ATTR_W-1:0]   r_attr;
  logic                r_xpart;
  logic [7:0]          r_prefetch;
  logic                r_line_done;

  logic w_load;
  logic w_shift_ready;
  logic w_last_shift;
  logic w_busy;
  logic w_second_half;
  logic w_last_cell;
  logic w_unused_mem_bits;

  assign w_unused_mem_bits = &{1'b0, mem_data[15:ATTR_W]};

  // A double-width cell whose left half is being loaded still owes its right half.
  assign w_second_half = r_attr[ATTR_XSIZE] & ~r_xpart;
  assign w_last_cell   = (r_cells_left == C_ONE);
  assign w_load        = (r_state == ST_FULL) && w_shift_ready && !line_start;

  // ---------------------------------------------------------------- outputs
  assign mem_rd       = (r_state == ST_FETCH);
  assign mem_addr     = r_col_addr;
  // Generator controls only change on entry to GEN (attr in WAIT, xpart on load).
  assign cg_index     = r_attr[CHAR_W-1:0];
  assign cg_ychar     = r_ychar;
  assign cg_xsize     = r_attr[ATTR_XSIZE];
  assign cg_ysize     = r_attr[ATTR_YSIZE];
  assign cg_xpart     = r_xpart;
  assign cg_ypart     = r_attr[ATTR_YPART];
  assign cg_underline = r_attr[ATTR_UNDERLINE];
  assign cg_invert    = r_attr[ATTR_INVERT];
  assign pixel_valid  = w_busy;
  assign line_done    = r_line_done;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (line_start) begin
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_FETCH: w_state_nxt = ST_WAIT;
        ST_WAIT:  w_state_nxt = ST_GEN;
        ST_GEN:   w_state_nxt = ST_CAPT;
        ST_CAPT:  w_state_nxt = ST_FULL;
        ST_FULL: begin
          if (w_load) begin
            if (w_last_cell) begin
              w_state_nxt = ST_IDLE;     // shifter drains the final cell
            end else if (w_second_half) begin
              w_state_nxt = ST_GEN;      // right half reuses the fetched word
            end else begin
              w_state_nxt = ST_FETCH;
            end
          end
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_addr   <= '0;
      r_cells_left <= '0;
      r_ychar      <= '0;
      r_attr       <= '0;
      r_xpart      <= 1'b0;
      r_prefetch   <= 8'd0;
      r_line_done  <= 1'b0;
    end else if (line_start) begin
      // Abort/start: any read in flight is superseded by the new FETCH.
      r_col_addr   <= row_addr;
      r_ychar      <= ychar_in;
      r_cells_left <= C_COLUMNS;
      r_prefetch   <= 8'd0;
      r_line_done  <= 1'b0;
    end else begin
      r_line_done <= w_last_shift && (r_cells_left == '0);
      case (r_state)
        ST_WAIT: begin
          r_attr  <= mem_data[ATTR_W-1:0];
          r_xpart <= 1'b0;
        end
        ST_CAPT: begin
          r_prefetch <= cg_pixels;
        end
        ST_FULL: begin
          if (w_load) begin
            r_cells_left <= r_cells_left - C_ONE;
            if (!w_last_cell) begin
              if (w_second_half) begin
                r_xpart    <= 1'b1;
                r_col_addr <= r_col_addr + ADDR_W'(2);
              end else if (!r_attr[ATTR_XSIZE]) begin
                r_col_addr <= r_col_addr + ADDR_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  text_pixel_shifter u_shifter (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (line_start),
    .pixel_en      (pixel_en),
    .load          (w_load),
    .load_data     (r_prefetch),
    .cells_pending (r_cells_left != '0),
    .pixel         (pixel),
    .busy          (w_busy),
    .ready         (w_shift_ready),
    .last_shift    (w_last_shift),
    .underrun      (underrun)
  );

endmodule
`default_nettype wire
